lc3b_mem_responder: RTL and testbench

Synthesizable memory-side responder for the LC-3b CPU memory interface. It accepts mem_read/mem_write requests held by the CPU control FSM and returns a one-cycle mem_resp after a programmable latency. Byte-masked writes go to an internal word array. It sits between the CPU datapath/control and the top-level testbench, and is used as the memory for mp0-class cores.

---
 rtl/lc3b_types.sv | 25 ++
 rtl/lc3b_mem_array.sv | 44 ++++
 rtl/lc3b_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared types for the LC-3b memory interface.
//   - lc3b_word      : 16-bit machine word
//   - lc3b_mem_wmask : byte-lane write mask, bit0 = [7:0], bit1 = [15:8]
//   - lc3b_mem_state : responder FSM states (IDLE/BUSY/RESP)
//   - lfsr8_next     : one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc3b_mem_state;

  // Taps at bits 8,6,5,4 (1-based) map to indices 7,5,4,3.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// ---------------------------------------------------------------------------
// lc3b_mem_array
//   2^ADDR_BITS x 16 word store with one shared index, a synchronous
//   byte-masked write port and a synchronous read port. Contents are not
//   reset.
// Ports:
//   clk    in   clock, rising edge
//   idx    in   word index for both ports
//   wr_en  in   write strobe (qualified per lane by wmask)
//   wmask  in   byte-lane mask, bit0 = [7:0], bit1 = [15:8]
//   wdata  in   write data
//   rd_en  in   read strobe; rdata updates on this edge, holds otherwise
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic                 wr_en,
  input  lc3b_mem_wmask        wmask,
  input  lc3b_word             wdata,
  input  logic                 rd_en,
  output lc3b_word             rdata
);

  lc3b_word mem_q [2**ADDR_BITS];
  lc3b_word rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wmask[0]) mem_q[idx][7:0]  <= wdata[7:0];
      if (wmask[1]) mem_q[idx][15:8] <= wdata[15:8];
    end
    if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
//   Memory-side responder for the LC-3b CPU memory interface. A request held
//   on mem_read/mem_write is accepted in IDLE, completes after LATENCY
//   cycles with a one-cycle mem_resp, and reads/writes an internal word
//   array (lc3b_mem_array).
//
//   Optional build macro LAT_JITTER_EN: adds 0..3 extra wait cycles per
//   transaction from an 8-bit LFSR (seed 8'hA5 on rst). Undefined: latency
//   is exactly LATENCY and no LFSR exists.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   mem_address[15:0] in  byte address; word index = mem_address[ADDR_BITS:1]
//   mem_read         in   read request, held until mem_resp
//   mem_write        in   write request, held until mem_resp
//   mem_byte_enable  in   byte-lane write mask
//   mem_wdata        in   write data
//   mem_rdata        out  read data, valid in the mem_resp cycle, then held
//   mem_resp         out  one-cycle completion pulse
//   proto_err        out  sticky protocol-error flag (cleared only by rst)
// ---------------------------------------------------------------------------
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          proto_err
);

  // Wide enough for LATENCY+3, the longest jittered latency.
  localparam int CNT_W = $clog2(LATENCY + 4);

  lc3b_mem_state        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic                 proto_err_q, proto_err_d;
  logic                 rdata_vld_q, rdata_vld_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  lc3b_mem_wmask        be_q, be_d;
  lc3b_word             wdata_q, wdata_d;

  // Operation presented to the array at the RESP-entry edge. In IDLE this is
  // the live request (LATENCY==1 goes straight to RESP), otherwise the
  // latched copy.
  logic                 acc_write;
  logic [ADDR_BITS-1:0] acc_idx;
  lc3b_mem_wmask        acc_be;
  lc3b_word             acc_wdata;
  logic                 go_resp;
  logic [1:0]           extra;
  logic [CNT_W-1:0]     total;
  lc3b_word             arr_rdata;

  logic unused_addr;
  assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

`ifdef LAT_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr8_next(lfsr_q);
  assign extra  = lfsr_q[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign extra = 2'b00;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    proto_err_d = proto_err_q;
    rdata_vld_d = rdata_vld_q;
    acc_write   = write_q;
    acc_idx     = idx_q;
    acc_be      = be_q;
    acc_wdata   = wdata_q;
    go_resp     = 1'b0;
    total       = CNT_W'(LATENCY) + CNT_W'(extra);

    case (state_q)
      IDLE: begin
        acc_write = mem_write;
        acc_idx   = mem_address[ADDR_BITS:1];
        acc_be    = mem_byte_enable;
        acc_wdata = mem_wdata;
        if (mem_read | mem_write) begin
          // Read+write together resolves to a write and flags the error.
          write_d = mem_write;
          idx_d   = mem_address[ADDR_BITS:1];
          be_d    = mem_byte_enable;
          wdata_d = mem_wdata;
          if (mem_read & mem_write) proto_err_d = 1'b1;
          if (total == CNT_W'(1)) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = total - CNT_W'(2);
          end
        end
      end
      BUSY: begin
        // Initiator dropped its request early; finish anyway but flag it.
        if (!(mem_read | mem_write)) proto_err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_resp && !acc_write) rdata_vld_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      proto_err_q <= 1'b0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      proto_err_q <= proto_err_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  // Gating with rst keeps a held request from touching the array while the
  // FSM is forced to IDLE.
  lc3b_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .idx   (acc_idx),
    .wr_en (go_resp & acc_write & ~rst),
    .wmask (acc_be),
    .wdata (acc_wdata),
    .rd_en (go_resp & ~acc_write & ~rst),
    .rdata (arr_rdata)
  );

  // Array read data is not reset; rdata_vld_q gives mem_rdata its reset
  // value of zero until the first completed read.
  assign mem_rdata = rdata_vld_q ? arr_rdata : 16'h0000;
  assign mem_resp  = (state_q == RESP);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;
  import lc3b_types::*;

  logic        clk;
  logic        rst;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .proto_err       (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. Returns the number
  // of edges until mem_resp is seen, and rdata/proto_err in that cycle. Drops
  // the request in the RESP cycle and checks the pulse is one cycle wide.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd,
                         output int lat, output logic [15:0] rdo, output logic peo);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_resp && lat < 20);
    rdo = mem_rdata;
    peo = proto_err;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'b0, mem_resp}, 32'd0);
  endtask

  int          lat;
  logic [15:0] rdv;
  logic        pev;
  logic        any_resp;

  initial begin
    rst = 1'b1;
    mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp",  {31'b0, mem_resp},  32'd0);
    chk("rst_rdata", {16'b0, mem_rdata}, 32'h0);
    chk("rst_perr",  {31'b0, proto_err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write then read.
    run_txn(1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, lat, rdv, pev);
    chk("wr_beef_lat", lat, 32'd3);
    chk("wr_beef_perr", {31'b0, pev}, 32'd0);
    run_txn(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rd_beef_lat", lat, 32'd3);
    chk("rd_beef_data", {16'b0, rdv}, 32'hBEEF);
    chk("rd_beef_perr", {31'b0, pev}, 32'd0);

    // Byte-lane writes.
    run_txn(1'b0, 1'b1, 16'h0010, 2'b01, 16'h1234, lat, rdv, pev);
    run_txn(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rd_be01_data", {16'b0, rdv}, 32'hBE34);
    run_txn(1'b0, 1'b1, 16'h0010, 2'b10, 16'hAB00, lat, rdv, pev);
    run_txn(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rd_be10_data", {16'b0, rdv}, 32'hAB34);

    // Odd address hits the same word.
    run_txn(1'b1, 1'b0, 16'h0011, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rd_odd_data", {16'b0, rdv}, 32'hAB34);

    // Address wrap: 0x0200 aliases 0x0000.
    run_txn(1'b0, 1'b1, 16'h0200, 2'b11, 16'h7777, lat, rdv, pev);
    run_txn(1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rd_wrap_data", {16'b0, rdv}, 32'h7777);

    // Back-to-back reads with the request held through turnaround.
    run_txn(1'b0, 1'b1, 16'h0002, 2'b11, 16'hC0DE, lat, rdv, pev);
    mem_read = 1'b1; mem_address = 16'h0000;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_resp && lat < 20);
    chk("b2b_first_lat", lat, 32'd3);
    chk("b2b_first_data", {16'b0, mem_rdata}, 32'h7777);
    mem_address = 16'h0002;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_resp && lat < 20);
    chk("b2b_gap", lat, 32'd4);
    chk("b2b_second_data", {16'b0, mem_rdata}, 32'hC0DE);
    mem_read = 1'b0;
    @(posedge clk); #1;
    chk("b2b_resp_drop", {31'b0, mem_resp}, 32'd0);

    // Empty byte mask: still responds, word unchanged.
    run_txn(1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, lat, rdv, pev);
    chk("be00_lat", lat, 32'd3);
    run_txn(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv, pev);
    chk("be00_data", {16'b0, rdv}, 32'hAB34);

    // Read+write together: treated as write, sticky error.
    run_txn(1'b1, 1'b1, 16'h0004, 2'b11, 16'h5A5A, lat, rdv, pev);
    chk("rw_lat", lat, 32'd3);
    chk("rw_perr", {31'b0, pev}, 32'd1);
    run_txn(1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000, lat, rdv, pev);
    chk("rw_rd_data", {16'b0, rdv}, 32'h5A5A);
    chk("rw_perr_sticky", {31'b0, pev}, 32'd1);

    // Asynchronous reset while BUSY.
    mem_read = 1'b1; mem_address = 16'h0010;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("arst_resp",  {31'b0, mem_resp},  32'd0);
    chk("arst_rdata", {16'b0, mem_rdata}, 32'h0);
    chk("arst_perr",  {31'b0, proto_err}, 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    any_resp = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (mem_resp) any_resp = 1'b1; end
    @(negedge clk) rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (mem_resp) any_resp = 1'b1; end
    chk("arst_no_resp", {31'b0, any_resp}, 32'd0);
    run_txn(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv, pev);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_data", {16'b0, rdv}, 32'hAB34);
    chk("post_rst_perr", {31'b0, pev}, 32'd0);

    // Request dropped while BUSY: still completes, error flagged.
    mem_read = 1'b1; mem_address = 16'h0010;
    lat = 0;
    @(posedge clk); #1; lat++;
    mem_read = 1'b0;
    while (!mem_resp && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("drop_lat", lat, 32'd3);
    chk("drop_data", {16'b0, mem_rdata}, 32'hAB34);
    chk("drop_perr", {31'b0, proto_err}, 32'd1);
    @(posedge clk); #1;
    chk("drop_resp_one_cycle", {31'b0, mem_resp}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
